fwrisc_regfile_mp: RTL and testbench
====================================

// Module: fwrisc_regfile_mp
// PURPOSE
//  Parametrised multi-port GPR file for fwrisc cores: NUM_RD registered read ports, NUM_WR write ports.
//  Hardware reset-clear sequencer, optional write-to-read bypass, per-register pending-write scoreboard.
//  Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).
//  CSRs are out of scope; only GPRs x0..x(N_REGS-1).
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  N_REGS      32  architectural regs incl. x0; legal 16 (RV32E) or 32
//  NUM_RD      2   read ports, 1..4
//  NUM_WR      1   write ports, 1..2
//  BYPASS      1   1: same-cycle write forwarded to read (write-first); 0: read-first
//  AW          $clog2(N_REGS)  derived address width, not overridden
// PORTS
//  clock      in   1               core clock
//  reset      in   1               synchronous, active-high
//  ready      out  1               1 once the reset-clear sweep is done
//  rs_raddr   in   NUM_RD*AW       read addresses, port i at [i*AW +: AW]
//  rs_rdata   out  NUM_RD*DATA_WIDTH  registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rs_busy    out  NUM_RD          comb: scoreboard busy bit of rs_raddr[i]
//  rd_waddr   in   NUM_WR*AW       write addresses
//  rd_wdata   in   NUM_WR*DATA_WIDTH  write data
//  rd_wen     in   NUM_WR          write enables
//  sb_set     in   1               mark sb_addr as pending write
//  sb_addr    in   AW              scoreboard set address
//  sb_count   out  AW+1            number of busy registers
// BEHAVIOUR
//  Reset (synchronous): rs_rdata=0, busy[]=0, sb_count=0, ready=0, FSM->INIT, init_idx=1.
//  FSM INIT: each cycle writes 0 to regs[init_idx], init_idx++.
//    After regs[N_REGS-1] is cleared -> RUN, ready=1 next cycle.
//    Sweep is N_REGS-1 cycles after reset deassertion.
//  INIT port behaviour:
//    rd_wen and sb_set ignored; rs_rdata reads 0; rs_busy=0.
//    Reset asserted in any state restarts INIT from idx 1.
//  RUN, write: rd_wen[j] && rd_waddr[j]!=0 -> regs[rd_waddr[j]] <= rd_wdata[j] at posedge.
//    Writes to x0 are dropped.
//    Both ports same addr: port NUM_WR-1 (highest index) wins.
//  RUN, read: 1-cycle latency; rs_rdata[i] at t+1 reflects rs_raddr[i] sampled at t.
//    x0 always reads 0.
//    BYPASS=1: matching same-cycle write (nonzero addr) returns rd_wdata, highest write port wins.
//    BYPASS=0: returns pre-write contents.
//  Scoreboard: busy[a] set by sb_set at a; cleared by any rd_wen[j] write to a.
//    Set and clear of the same addr in one cycle: set wins (new producer issued).
//    sb_set to x0 ignored; busy[0] always 0.
//    rs_busy[i]=busy[rs_raddr[i]] from registered state, no same-cycle forwarding.
//    sb_count = popcount(busy), updated with busy (registered); max N_REGS-1, never wraps.
//    sb_set to an already-busy reg: no count change.
//  Address bits beyond N_REGS (only if N_REGS<2^AW): n/a for legal values.
// TESTING
//  Reset, hold N_REGS-1 cycles -> ready=0 throughout, 1 after; all 32 regs read 0 on every port.
//  Write x5=0xDEADBEEF, read x5 same cycle:
//    BYPASS=1 -> 0xDEADBEEF at t+1; BYPASS=0 -> 0, then 0xDEADBEEF at t+2.
//  NUM_WR=2, both write x7 (0x1111, 0x2222) -> x7 reads 0x2222; write 0x1234 to x0 -> x0 reads 0.
//  sb_set x3, then x4 -> sb_count=2, rs_busy for x3=1; write x3 -> busy clears, count=1.
//    Same-cycle set+write x4 -> stays busy, count=1.
//  Reset asserted mid-INIT (cycle 10) after prior x9=0xA5A5A5A5:
//    sweep restarts, ready low 31 more cycles, x9 reads 0.
//  N_REGS=16, NUM_RD=4: random write/read/sb_set traffic vs reference model.
//    Zero mismatches over 10k cycles.

Source files
------------

// File: rtl/fwrisc_regfile_mp.sv
// fwrisc_regfile_mp: multi-port GPR file with reset-clear sweep, optional write-to-read bypass
// and a per-register pending-write scoreboard.
module fwrisc_regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(N_REGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         ready,
  input  logic [NUM_RD*AW-1:0]         rs_raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_rdata,
  output logic [NUM_RD-1:0]            rs_busy,
  input  logic [NUM_WR*AW-1:0]         rd_waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] rd_wdata,
  input  logic [NUM_WR-1:0]            rd_wen,
  input  logic                         sb_set,
  input  logic [AW-1:0]                sb_addr,
  output logic [AW:0]                  sb_count
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] init_idx;
  logic [DATA_WIDTH-1:0] regs [N_REGS];
  logic [N_REGS-1:0] busy, busy_nx;
  logic [AW:0] count_nx;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_nx;
  always_ff @(posedge clock) state <= reset ? INIT : state_nx;
  always_comb state_nx = (state == INIT && init_idx == AW'(N_REGS - 1)) ? RUN : state;
  always_comb ready = state == RUN;
  always_ff @(posedge clock)
    if (reset) init_idx <= AW'(1);
    else if (state == INIT) init_idx <= init_idx + AW'(1);
  // x0 is never stored; reads of it are forced to zero below
  always_ff @(posedge clock)
    if (!reset) begin
      if (state == INIT) regs[init_idx] <= '0;
      else
        for (int j = 0; j < NUM_WR; j++)
          if (rd_wen[j] && rd_waddr[j*AW +: AW] != '0)
            regs[rd_waddr[j*AW +: AW]] <= rd_wdata[j*DATA_WIDTH +: DATA_WIDTH];
    end
  always_comb begin
    rdata_nx = '0;
    for (int i = 0; i < NUM_RD; i++)
      if (ready && rs_raddr[i*AW +: AW] != '0) begin
        rdata_nx[i*DATA_WIDTH +: DATA_WIDTH] = regs[rs_raddr[i*AW +: AW]];
        for (int j = 0; j < NUM_WR; j++)
          if (BYPASS && rd_wen[j] && rd_waddr[j*AW +: AW] == rs_raddr[i*AW +: AW])
            rdata_nx[i*DATA_WIDTH +: DATA_WIDTH] = rd_wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
  end
  // set applied after clears so a newly issued producer keeps the register busy
  always_comb begin
    busy_nx = busy;
    if (ready) begin
      for (int j = 0; j < NUM_WR; j++)
        if (rd_wen[j]) busy_nx[rd_waddr[j*AW +: AW]] = 1'b0;
      if (sb_set) busy_nx[sb_addr] = 1'b1;
    end
    busy_nx[0] = 1'b0;
    count_nx = '0;
    for (int k = 0; k < N_REGS; k++) count_nx = count_nx + {{AW{1'b0}}, busy_nx[k]};
  end
  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < NUM_RD; i++) rs_busy[i] = ready && busy[rs_raddr[i*AW +: AW]];
  end
  always_ff @(posedge clock)
    if (reset) begin
      busy <= '0;
      sb_count <= '0;
      rs_rdata <= '0;
    end else begin
      busy <= busy_nx;
      sb_count <= count_nx;
      rs_rdata <= rdata_nx;
    end
endmodule

// File: tb/tb_fwrisc_regfile_mp.sv
// tb_fwrisc_regfile_mp: two register-file configurations driven by shared stimulus,
// checked through an expectation queue against a per-instance architectural model.
module tb_fwrisc_regfile_mp;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;
  logic [4:0] ra [4];
  logic [4:0] wa [2];
  logic [31:0] wd [2];
  logic [1:0] wen;
  logic sb_set;
  logic [4:0] sb_addr;
  logic a_ready, b_ready;
  logic [63:0] a_rdata;
  logic [127:0] b_rdata;
  logic [1:0] a_busy;
  logic [3:0] b_busy;
  logic [5:0] a_cnt;
  logic [4:0] b_cnt;
  fwrisc_regfile_mp #(.DATA_WIDTH(32), .N_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) u_a (
    .clock(clock), .reset(reset), .ready(a_ready),
    .rs_raddr({ra[1], ra[0]}), .rs_rdata(a_rdata), .rs_busy(a_busy),
    .rd_waddr({wa[1], wa[0]}), .rd_wdata({wd[1], wd[0]}), .rd_wen(wen),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_count(a_cnt)
  );
  fwrisc_regfile_mp #(.DATA_WIDTH(32), .N_REGS(16), .NUM_RD(4), .NUM_WR(2), .BYPASS(1'b0)) u_b (
    .clock(clock), .reset(reset), .ready(b_ready),
    .rs_raddr({ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]}), .rs_rdata(b_rdata), .rs_busy(b_busy),
    .rd_waddr({wa[1][3:0], wa[0][3:0]}), .rd_wdata({wd[1], wd[0]}), .rd_wen(wen),
    .sb_set(sb_set), .sb_addr(sb_addr[3:0]), .sb_count(b_cnt)
  );
  typedef struct packed {
    logic [1:0] rdy;
    logic [1:0][5:0] cnt;
    logic [1:0][3:0][31:0] rd;
    logic [1:0][3:0] bsy;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [31:0] m_regs [2][32];
  bit m_busy [2][32];
  int m_init [2];
  int pass_n = 0, check_n = 0, cyc = 0;
  // d=0: 32 regs with bypass; d=1: 16 regs, read-first
  task automatic model_step(input int d, inout exp_t e);
    int n, a, c;
    logic [31:0] v;
    n = d ? 16 : 32;
    for (int i = 0; i < 4; i++) e.rd[d][i] = '0;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[d][r] = '0;
        m_busy[d][r] = 0;
      end
      m_init[d] = n - 1;
    end else if (m_init[d] > 0) m_init[d]--;
    else begin
      for (int i = 0; i < 4; i++) begin
        a = int'(ra[i]) % n;
        v = m_regs[d][a];
        for (int j = 0; j < 2; j++)
          if (d == 0 && wen[j] && int'(wa[j]) % n == a) v = wd[j];
        e.rd[d][i] = (a == 0) ? 32'h0 : v;
      end
      for (int j = 0; j < 2; j++)
        if (wen[j]) begin
          a = int'(wa[j]) % n;
          if (a != 0) m_regs[d][a] = wd[j];
          m_busy[d][a] = 0;
        end
      a = int'(sb_addr) % n;
      if (sb_set && a != 0) m_busy[d][a] = 1;
    end
    e.rdy[d] = m_init[d] == 0;
    c = 0;
    for (int r = 0; r < n; r++) c += int'(m_busy[d][r]);
    e.cnt[d] = 6'(c);
    for (int i = 0; i < 4; i++) e.bsy[d][i] = m_busy[d][int'(ra[i]) % n] && e.rdy[d];
  endtask
  task automatic drive();
    exp_t e;
    e = '0;
    model_step(0, e);
    model_step(1, e);
    q.push_back(e);
    @(posedge clock);
    #2;
  endtask
  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    check_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", nm, i, cyc, got, exp);
  endtask
  initial forever begin
    @(posedge clock);
    #1;
    cyc++;
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("a.ready", 0, 32'(a_ready), 32'(me.rdy[0]));
      chk("b.ready", 0, 32'(b_ready), 32'(me.rdy[1]));
      chk("a.sb_count", 0, 32'(a_cnt), 32'(me.cnt[0]));
      chk("b.sb_count", 0, 32'(b_cnt), 32'(me.cnt[1][4:0]));
      for (int i = 0; i < 2; i++) begin
        chk("a.rs_rdata", i, a_rdata[i*32 +: 32], me.rd[0][i]);
        chk("a.rs_busy", i, 32'(a_busy[i]), 32'(me.bsy[0][i]));
      end
      for (int i = 0; i < 4; i++) begin
        chk("b.rs_rdata", i, b_rdata[i*32 +: 32], me.rd[1][i]);
        chk("b.rs_busy", i, 32'(b_busy[i]), 32'(me.bsy[1][i]));
      end
    end
  end
  task automatic idle();
    reset = 1'b0;
    wen = '0;
    sb_set = 1'b0;
  endtask
  task automatic rand_in(input int odds);
    reset = odds > 0 && $urandom_range(0, odds - 1) == 0;
    for (int i = 0; i < 4; i++) ra[i] = 5'($urandom);
    for (int j = 0; j < 2; j++) begin
      wa[j] = ($urandom_range(0, 3) == 0) ? ra[j] : 5'($urandom);
      wd[j] = $urandom;
    end
    if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
    wen = 2'($urandom);
    sb_set = $urandom_range(0, 2) == 0;
    sb_addr = ($urandom_range(0, 2) == 0) ? ra[0] : 5'($urandom);
  endtask
  initial begin
    reset = 1'b1;
    wen = '0;
    sb_set = 1'b0;
    sb_addr = '0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
    for (int j = 0; j < 2; j++) begin
      wa[j] = '0;
      wd[j] = '0;
    end
    drive();
    drive();
    // traffic during the sweep must be ignored by both instances
    repeat (15) begin
      rand_in(0);
      drive();
    end
    idle();
    repeat (16) drive();
    for (int r = 0; r < 32; r++) begin
      for (int i = 0; i < 4; i++) ra[i] = 5'(r + i);
      drive();
    end
    wen = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5; ra[1] = 5'd5;
    drive();
    idle();
    drive();
    drive();
    wen = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h1111; wd[1] = 32'h2222; ra[0] = 5'd7;
    drive();
    idle();
    drive();
    wen = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234; ra[0] = 5'd0; ra[1] = 5'd0;
    drive();
    idle();
    drive();
    sb_set = 1'b1; sb_addr = 5'd3; ra[0] = 5'd3; ra[1] = 5'd4;
    drive();
    sb_addr = 5'd4;
    drive();
    sb_set = 1'b0; wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'h33;
    drive();
    sb_set = 1'b1; sb_addr = 5'd4; wa[0] = 5'd4; wd[0] = 32'h44;
    drive();
    idle();
    drive();
    wen = 2'b01; wa[0] = 5'd9; wd[0] = 32'hA5A5A5A5; ra[0] = 5'd9; ra[1] = 5'd9;
    drive();
    idle();
    drive();
    reset = 1'b1;
    drive();
    reset = 1'b0;
    repeat (10) drive();
    reset = 1'b1;
    drive();
    reset = 1'b0;
    repeat (33) drive();
    repeat (10000) begin
      rand_in(2000);
      drive();
    end
    idle();
    drive();
    chk("queue_drained", 0, 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_n, check_n);
    $finish;
  end
endmodule
